// File: rtl/led_breath_ctrl.sv
// Breathing-LED driver: owns the PWM period counter and ramps the duty value
// 0..100 % and back, changing duty and rate only on period boundaries.
module led_breath_ctrl #(
  parameter int unsigned CLK_HZ           = 27_000_000,
  parameter int unsigned DEFAULT_RATE     = 1000,
  parameter int unsigned DUTY_STEP        = 1,
  parameter int unsigned PERIODS_PER_STEP = 10,
  parameter int unsigned HOLD_PERIODS     = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] rate_in,
  output logic [31:0] cnt,
  output logic [31:0] duty,
  output logic [31:0] rate,
  output logic        period_tick,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } phase_t;

  localparam logic [31:0] CLK_HZ_W  = 32'(CLK_HZ);
  localparam logic [31:0] RATE_RST  = (DEFAULT_RATE == 0) ? 32'd1 : 32'(DEFAULT_RATE);
  localparam logic [31:0] STEP      = (DUTY_STEP > 100) ? 32'd100 : 32'(DUTY_STEP);
  localparam logic [31:0] STEP_LAST = (PERIODS_PER_STEP < 1) ? 32'd0 : 32'(PERIODS_PER_STEP - 1);
  localparam logic [31:0] HOLD_LAST = (HOLD_PERIODS < 1) ? 32'd0 : 32'(HOLD_PERIODS - 1);
  localparam logic [31:0] DUTY_MAX  = 32'd100;

  phase_t      state;
  logic [31:0] step_cnt;
  logic [31:0] hold_cnt;
  logic [31:0] quotient;
  logic [31:0] limit;
  logic [31:0] rate_sane;
  logic [31:0] duty_up;
  logic [31:0] duty_dn;
  logic        wrap;
  logic        step_done;
  logic        hold_done;

  // rate is never 0, so the divider always has a legal divisor.
  assign quotient  = CLK_HZ_W / rate;
  assign limit     = (quotient == 32'd0) ? 32'd0 : quotient - 32'd1;
  assign rate_sane = (rate_in == 32'd0) ? 32'd1 : rate_in;
  assign wrap      = en && (state != IDLE) && (cnt >= limit);
  assign step_done = (step_cnt >= STEP_LAST);
  assign hold_done = (hold_cnt >= HOLD_LAST);
  assign duty_up   = (duty >= DUTY_MAX - STEP) ? DUTY_MAX : duty + STEP;
  assign duty_dn   = (duty <= STEP) ? 32'd0 : duty - STEP;
  assign phase     = state;

  // NOTE: every register here is updated with <= so all of them sample the
  // same pre-edge values; blocking = would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      duty        <= 32'd0;
      rate        <= RATE_RST;
      period_tick <= 1'b0;
      step_cnt    <= 32'd0;
      hold_cnt    <= 32'd0;
    end else if (!en) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      duty        <= 32'd0;
      period_tick <= 1'b0;
      step_cnt    <= 32'd0;
      hold_cnt    <= 32'd0;
      if (state == IDLE) rate <= rate_sane;
    end else if (state == IDLE) begin
      // Entering RISE starts a fresh period at cnt=0.
      state       <= RISE;
      cnt         <= 32'd0;
      duty        <= 32'd0;
      period_tick <= 1'b1;
      rate        <= rate_sane;
      step_cnt    <= 32'd0;
      hold_cnt    <= 32'd0;
    end else if (wrap) begin
      cnt         <= 32'd0;
      period_tick <= 1'b1;
      rate        <= rate_sane;
      unique case (state)
        RISE: begin
          if (step_done) begin
            step_cnt <= 32'd0;
            duty     <= duty_up;
            if (duty_up == DUTY_MAX) begin
              state    <= HOLD_HI;
              hold_cnt <= 32'd0;
            end
          end else begin
            step_cnt <= step_cnt + 32'd1;
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            state    <= FALL;
            hold_cnt <= 32'd0;
            step_cnt <= 32'd0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        FALL: begin
          if (step_done) begin
            step_cnt <= 32'd0;
            duty     <= duty_dn;
            if (duty_dn == 32'd0) begin
              state    <= HOLD_LO;
              hold_cnt <= 32'd0;
            end
          end else begin
            step_cnt <= step_cnt + 32'd1;
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            state    <= RISE;
            hold_cnt <= 32'd0;
            step_cnt <= 32'd0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      cnt         <= cnt + 32'd1;
      period_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Bench for led_breath_ctrl: per-cycle expected records queued as stimulus is
// driven and compared one cycle later, plus async-reset and edge sequences.
module tb_led_breath_ctrl;

  typedef struct {
    logic        en;
    logic [31:0] rate_in;
    logic [31:0] cnt;
    logic [31:0] duty;
    logic [31:0] rate;
    logic        tick;
    logic [2:0]  phase;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] rate_in;
  logic [31:0] cnt;
  logic [31:0] duty;
  logic [31:0] rate;
  logic        period_tick;
  logic [2:0]  phase;

  int    n_vec = 0;
  int    n_err = 0;
  string tag   = "reset";
  vec_t  tbl[$];
  vec_t  exp_q[$];

  // Duty and phase of successive periods for STEP=30, 1 period/step, hold 2.
  logic [31:0] duty_seq [14] = '{0, 30, 60, 90, 100, 100, 100, 70, 40, 10, 0, 0, 0, 30};
  logic [2:0]  phase_seq[14] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};

  led_breath_ctrl #(
    .CLK_HZ          (100),
    .DEFAULT_RATE    (1000),
    .DUTY_STEP       (30),
    .PERIODS_PER_STEP(1),
    .HOLD_PERIODS    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rate_in    (rate_in),
    .cnt        (cnt),
    .duty       (duty),
    .rate       (rate),
    .period_tick(period_tick),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic [31:0] rin, input logic [31:0] c,
                              input logic [31:0] d, input logic [31:0] r, input logic t,
                              input logic [2:0] p);
    vec_t v;
    v.en = e; v.rate_in = rin; v.cnt = c; v.duty = d; v.rate = r; v.tick = t; v.phase = p;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d %s: got %0d expected %0d", tag, n_vec, name, act, exp);
    end
  endtask

  task automatic compare(input vec_t e);
    n_vec++;
    check("cnt", cnt, e.cnt);
    check("duty", duty, e.duty);
    check("rate", rate, e.rate);
    check("period_tick", {31'b0, period_tick}, {31'b0, e.tick});
    check("phase", {29'b0, phase}, {29'b0, e.phase});
  endtask

  // Drive one vector, then compare the outputs the DUT produces after the edge.
  task automatic apply(input vec_t v);
    en      = v.en;
    rate_in = v.rate_in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare(exp_q.pop_front());
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    rate_in = 32'd10;
    #12;
    compare(mk(0, 10, 0, 0, 1000, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle tracking, then period 0..9 and the full ramp at rate 10.
    tbl.push_back(mk(0, 10, 0, 0, 10, 0, 0));
    for (int k = 0; k < 140; k++)
      tbl.push_back(mk(1, 10, 32'(k % 10), duty_seq[k / 10], 10, (k % 10) == 0, phase_seq[k / 10]));
    // rate_in 10->20 while cnt=3: current period still runs to 9, then 0..4.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, (k >= 4) ? 32'd20 : 32'd10, 32'(k), 60, 10, k == 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 20, 32'(k), 90, 20, k == 0, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 20, 32'(k), 100, 20, k == 0, 2));

    tag = "table";
    foreach (tbl[i]) apply(tbl[i]);

    // en=0 coincident with a wrap: wrap is ignored, rate not reloaded.
    tag = "disable";
    apply(mk(0, 10, 0, 0, 20, 0, 0));
    apply(mk(0, 10, 0, 0, 10, 0, 0));
    for (int k = 0; k < 23; k++)
      apply(mk(1, 10, 32'(k % 10), duty_seq[k / 10], 10, (k % 10) == 0, phase_seq[k / 10]));
    apply(mk(0, 10, 0, 0, 10, 0, 0));
    tag = "reenable";
    for (int k = 0; k < 11; k++)
      apply(mk(1, 10, 32'(k % 10), duty_seq[k / 10], 10, (k % 10) == 0, phase_seq[k / 10]));

    tag = "rate_zero";
    apply(mk(0, 0, 0, 0, 10, 0, 0));
    apply(mk(0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 101; k++)
      apply(mk(1, 0, 32'(k % 100), (k < 100) ? 32'd0 : 32'd30, 1, (k % 100) == 0, 1));

    // Rate above CLK_HZ: limit 0, tick stays high, FSM steps every cycle.
    tag = "rate_over";
    apply(mk(0, 101, 0, 0, 1, 0, 0));
    apply(mk(0, 101, 0, 0, 101, 0, 0));
    for (int c = 0; c < 14; c++)
      apply(mk(1, 101, 0, duty_seq[c], 101, 1, phase_seq[c]));
    apply(mk(1, 101, 0, 60, 101, 1, 1));

    // Asynchronous reset mid-ramp, observed before any clock edge.
    tag = "async_reset";
    rst_n = 1'b0;
    #2;
    compare(mk(0, 101, 0, 0, 1000, 0, 0));
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(0, 101, 0, 0, 101, 0, 0));
    apply(mk(1, 101, 0, 0, 101, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
